// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down counter with prescaler, load/clear,
// wrap-or-saturate bounds, a one-cycle terminal-count pulse and a sticky
// overflow flag.
module mod_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE = 1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Prescaler needs at least one bit even when every enabled cycle steps.
  localparam int              PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV   = WIDTH'(MAX_VAL);
  localparam logic [PSW-1:0]  PS_LAST = PSW'(PRESCALE - 1);

  logic [WIDTH-1:0] r_count;
  logic [PSW-1:0]   r_ps;
  logic             r_tc;
  logic             r_ovf;

  logic             w_ps_last;
  logic             w_step;
  logic             w_at_bound;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_step_val;
  logic [PSW-1:0]   w_ps_next;

  assign w_ps_last  = (r_ps == PS_LAST);
  assign w_step     = en & w_ps_last;
  assign w_ps_next  = w_ps_last ? '0 : r_ps + PSW'(1);
  // Loads above the modulus are clamped so count never leaves 0..MAX_VAL.
  assign w_load_val = (load_val > MAXV) ? MAXV : load_val;
  // Bound depends on direction: MAX_VAL going up, zero going down.
  assign w_at_bound = up_dn ? (r_count == MAXV) : (r_count == '0);

  // Next count for a step: move one, or wrap/hold when at the bound.
  always_comb begin
    w_step_val = r_count;
    if (up_dn) begin
      if (!w_at_bound)    w_step_val = r_count + WIDTH'(1);
      else if (!SATURATE) w_step_val = '0;
    end else begin
      if (!w_at_bound)    w_step_val = r_count - WIDTH'(1);
      else if (!SATURATE) w_step_val = MAXV;
    end
  end

  // Counter state: rst > clear > load > step > hold; tc is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_ps    <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_ps    <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (load) begin
      r_count <= w_load_val;
      r_ps    <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (en) r_ps <= w_ps_next;
      if (w_step) begin
        r_count <= w_step_val;
        if (w_at_bound) begin
          r_tc  <= 1'b1;
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed vectors against three parameterisations of
// mod_counter (wrap, saturate, prescaled) sharing one clock and reset.
module tb_mod_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // A: WIDTH=4, MAX_VAL=9, PRESCALE=1, wrap
  logic       en_a, up_a, ld_a, clr_a;
  logic [3:0] lv_a, cnt_a;
  logic       tc_a, ovf_a;
  // B: WIDTH=4, MAX_VAL=5, PRESCALE=1, saturate
  logic       en_b, up_b, ld_b, clr_b;
  logic [3:0] lv_b, cnt_b;
  logic       tc_b, ovf_b;
  // C: WIDTH=4, MAX_VAL=9, PRESCALE=3, wrap
  logic       en_c, up_c, ld_c, clr_c;
  logic [3:0] lv_c, cnt_c;
  logic       tc_c, ovf_c;

  mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .up_dn(up_a), .load(ld_a), .load_val(lv_a),
    .clear(clr_a), .count(cnt_a), .tc(tc_a), .ovf(ovf_a));
  mod_counter #(.WIDTH(4), .MAX_VAL(5), .PRESCALE(1), .SATURATE(1'b1)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .up_dn(up_b), .load(ld_b), .load_val(lv_b),
    .clear(clr_b), .count(cnt_b), .tc(tc_b), .ovf(ovf_b));
  mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3), .SATURATE(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(en_c), .up_dn(up_c), .load(ld_c), .load_val(lv_c),
    .clear(clr_c), .count(cnt_c), .tc(tc_c), .ovf(ovf_c));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled here, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    en_a = 0; up_a = 1; ld_a = 0; clr_a = 0; lv_a = 0;
    en_b = 0; up_b = 1; ld_b = 0; clr_b = 0; lv_b = 0;
    en_c = 0; up_c = 1; ld_c = 0; clr_c = 0; lv_c = 0;

    // Reset state, before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst_cnt_a", 32'(cnt_a), 0);
    chk("rst_tc_a",  32'(tc_a),  0);
    chk("rst_ovf_a", 32'(ovf_a), 0);
    chk("rst_cnt_c", 32'(cnt_c), 0);
    #9 rst = 1'b0;  // t=12, between edges
    en_a = 1; up_a = 1;

    // A: up count with wrap at 9
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk($sformatf("up_cnt_e%0d", e), 32'(cnt_a), 32'(e % 10));
      chk($sformatf("up_tc_e%0d",  e), 32'(tc_a),  (e == 10) ? 1 : 0);
      chk($sformatf("up_ovf_e%0d", e), 32'(ovf_a), (e >= 10) ? 1 : 0);
    end

    // A: load 3 (with en high: load wins), then count down through zero
    ld_a = 1; lv_a = 4'd3;
    tick();
    ld_a = 0;
    chk("ld3_cnt", 32'(cnt_a), 3);
    chk("ld3_tc",  32'(tc_a),  0);
    chk("ld3_ovf_kept", 32'(ovf_a), 1);
    up_a = 0;
    begin
      int exp_d [4] = '{2, 1, 0, 9};
      for (int i = 0; i < 4; i++) begin
        tick();
        chk($sformatf("dn_cnt_%0d", i), 32'(cnt_a), 32'(exp_d[i]));
        chk($sformatf("dn_tc_%0d",  i), 32'(tc_a),  (i == 3) ? 1 : 0);
      end
    end

    // A: load above MAX_VAL clamps
    en_a = 0; ld_a = 1; lv_a = 4'd14;
    tick();
    ld_a = 0;
    chk("ld14_clamp", 32'(cnt_a), 9);

    // A: clear beats load
    clr_a = 1; ld_a = 1; lv_a = 4'd5;
    tick();
    clr_a = 0; ld_a = 0;
    chk("clrld_cnt", 32'(cnt_a), 0);
    chk("clrld_ovf", 32'(ovf_a), 0);

    // A: load beats step
    en_a = 1; up_a = 1; ld_a = 1; lv_a = 4'd6;
    tick();
    ld_a = 0;
    chk("ldstep_cnt", 32'(cnt_a), 6);
    tick();
    chk("after_ldstep", 32'(cnt_a), 7);
    en_a = 0;

    // B: saturate up from 0
    en_b = 1; up_b = 1;
    for (int s = 1; s <= 8; s++) begin
      tick();
      chk($sformatf("sat_cnt_s%0d", s), 32'(cnt_b), (s < 5) ? 32'(s) : 5);
      chk($sformatf("sat_tc_s%0d",  s), 32'(tc_b),  (s >= 6) ? 1 : 0);
    end
    chk("sat_ovf", 32'(ovf_b), 1);
    // B: down from 0 holds with tc each step
    ld_b = 1; lv_b = 4'd0;
    tick();
    ld_b = 0; up_b = 0;
    chk("sat_ld0_tc", 32'(tc_b), 0);
    for (int s = 0; s < 2; s++) begin
      tick();
      chk($sformatf("sat_dn_cnt_%0d", s), 32'(cnt_b), 0);
      chk($sformatf("sat_dn_tc_%0d",  s), 32'(tc_b),  1);
    end
    en_b = 0;
    tick();
    chk("sat_tc_drop", 32'(tc_b), 0);

    // C: prescale 3 -> steps on edges 3, 6, 9
    en_c = 1; up_c = 1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk($sformatf("ps_cnt_e%0d", e), 32'(cnt_c), 32'(e / 3));
    end
    // C: en dropped 2 cycles mid-phase delays the step by 2 edges
    tick();
    chk("ps_e10", 32'(cnt_c), 3);
    en_c = 0;
    tick(); chk("ps_e11_hold", 32'(cnt_c), 3);
    tick(); chk("ps_e12_hold", 32'(cnt_c), 3);
    en_c = 1;
    tick(); chk("ps_e13", 32'(cnt_c), 3);
    tick(); chk("ps_e14_step", 32'(cnt_c), 4);
    // C: load on edge 2 of a phase restarts prescaler; next step on edge 5
    tick(); chk("ps_ld_e1", 32'(cnt_c), 4);
    ld_c = 1; lv_c = 4'd2;
    tick(); ld_c = 0;
    chk("ps_ld_e2", 32'(cnt_c), 2);
    tick(); chk("ps_ld_e3", 32'(cnt_c), 2);
    tick(); chk("ps_ld_e4", 32'(cnt_c), 2);
    tick(); chk("ps_ld_e5", 32'(cnt_c), 3);

    // C: reach 7, then async reset between edges
    ld_c = 1; lv_c = 4'd6;
    tick(); ld_c = 0;
    tick(); tick(); tick();
    chk("pre_rst_cnt", 32'(cnt_c), 7);
    #3 rst = 1'b1;
    #1;
    chk("arst_cnt_c", 32'(cnt_c), 0);
    chk("arst_tc_c",  32'(tc_c),  0);
    chk("arst_ovf_c", 32'(ovf_c), 0);
    chk("arst_ovf_b", 32'(ovf_b), 0);
    #1 rst = 1'b0;
    tick(); chk("rel_e1", 32'(cnt_c), 0);
    tick(); chk("rel_e2", 32'(cnt_c), 0);
    tick(); chk("rel_e3", 32'(cnt_c), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
